// File: rtl/fp16_pkg.sv
// Shared binary16 constants, stage-A bundle type and overflow-result helper
// for the normalize/round back end.
package fp16_pkg;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RDN = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RTZ = 2'b11;

    localparam logic [4:0]  EXP_MAX  = 5'h1F;
    localparam logic [14:0] F16_INF  = 15'h7C00;
    localparam logic [14:0] F16_MAXF = 15'h7BFF;

    localparam int CARRY  = 14;
    localparam int HIDDEN = 13;
    localparam int LSB    = 3;

    // Result class decided in stage A; only K_FIN goes through rounding.
    typedef enum logic [2:0] {
        K_FIN  = 3'd0,
        K_ZERO = 3'd1,
        K_NAN  = 3'd2,
        K_INF  = 3'd3,
        K_OVF  = 3'd4
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic [1:0]  rm;
        logic        sign;
        logic [9:0]  nan_frac;
        logic [5:0]  exp;
        logic [13:0] frac;
    } norm_t;

    function automatic logic [15:0] ovf_result(input logic [1:0] rm, input logic sign);
        logic to_inf;
        to_inf = (rm == RM_RNE) || ((rm == RM_RDN) && sign) || ((rm == RM_RUP) && !sign);
        return {sign, (to_inf ? F16_INF : F16_MAXF)};
    endfunction

endpackage

// File: rtl/lzc14.sv
// Combinational leading-zero counter over 14 bits; an all-zero input counts 14.
module lzc14 (
    input  logic [13:0] a,
    output logic [3:0]  cnt
);

    always_comb begin
        cnt = 4'd14;
        // Ascending scan: the highest set bit is the last one to write cnt.
        for (int i = 0; i < 14; i++) begin
            if (a[i]) cnt = 4'(13 - i);
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Binary16 normalize (stage A) and round/pack (stage B) back end, two-entry
// valid/ready pipeline with combinational stall propagation.
module fp_norm_round
    import fp16_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_rm,
    input  logic        in_is_nan,
    input  logic        in_is_inf,
    input  logic [9:0]  in_inf_nan_frac,
    input  logic        in_sign,
    input  logic [4:0]  in_exp,
    input  logic [14:0] in_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_ovf,
    output logic        out_inexact
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; valid holds its data stable until accepted, and ready from a
    // stage depends only on that stage's occupancy and the stage after it.
    logic  a_valid, b_valid;
    logic  a_adv, b_adv;
    norm_t a_d, a_q;

    assign b_adv     = !b_valid || out_ready;
    assign a_adv     = !a_valid || b_adv;
    assign in_ready  = a_adv;
    assign out_valid = b_valid;

    logic [3:0] lz;
    logic [5:0] exp6;

    lzc14 u_lzc (
        .a   (in_frac[13:0]),
        .cnt (lz)
    );

    assign exp6 = {1'b0, in_exp};

    always_comb begin
        a_d          = '0;
        a_d.rm       = in_rm;
        a_d.sign     = in_sign;
        a_d.nan_frac = in_inf_nan_frac;
        a_d.exp      = exp6;
        a_d.frac     = in_frac[13:0];
        if (in_is_nan) begin
            a_d.kind = K_NAN;
        end else if (in_is_inf) begin
            a_d.kind = K_INF;
        end else if (in_frac[CARRY]) begin
            a_d.frac = {in_frac[14:2], in_frac[1] | in_frac[0]};
            a_d.exp  = exp6 + 6'd1;
        end else if (in_frac == 15'd0) begin
            a_d.kind = K_ZERO;
        end else if (in_exp != 5'd0) begin
            // Shift limited so the exponent never goes below the denormal range.
            if ({2'b00, lz} < exp6) begin
                a_d.frac = in_frac[13:0] << lz;
                a_d.exp  = exp6 - {2'b00, lz};
            end else begin
                a_d.frac = in_frac[13:0] << (in_exp - 5'd1);
                a_d.exp  = 6'd0;
            end
        end
        if ((a_d.kind == K_FIN) && (a_d.exp >= 6'd31)) a_d.kind = K_OVF;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            a_valid <= 1'b0;
            a_q     <= '0;
        end else if (a_adv) begin
            a_valid <= in_valid;
            a_q     <= a_d;
        end
    end

    logic        inc, grs_any;
    logic [11:0] sum;
    logic [5:0]  exp_r;
    logic [9:0]  man;
    logic [15:0] res_d;
    logic        ovf_d, inx_d;

    always_comb begin
        grs_any = |a_q.frac[2:0];
        case (a_q.rm)
            RM_RNE:  inc = a_q.frac[2] & ((|a_q.frac[1:0]) | a_q.frac[LSB]);
            RM_RDN:  inc = a_q.sign & grs_any;
            RM_RUP:  inc = !a_q.sign & grs_any;
            default: inc = 1'b0;
        endcase
        sum   = {1'b0, a_q.frac[HIDDEN:LSB]} + {11'd0, inc};
        exp_r = a_q.exp;
        man   = sum[9:0];
        if (sum[11]) begin
            man   = sum[10:1];
            exp_r = a_q.exp + 6'd1;
        end else if ((a_q.exp == 6'd0) && sum[10]) begin
            exp_r = 6'd1;
        end
        res_d = {a_q.sign, exp_r[4:0], man};
        ovf_d = 1'b0;
        inx_d = grs_any;
        case (a_q.kind)
            K_NAN: begin
                res_d = {a_q.sign, EXP_MAX, a_q.nan_frac};
                inx_d = 1'b0;
            end
            K_INF: begin
                res_d = {a_q.sign, EXP_MAX, 10'h000};
                inx_d = 1'b0;
            end
            K_ZERO: begin
                res_d = {a_q.sign, 15'h0000};
                inx_d = 1'b0;
            end
            K_OVF: begin
                res_d = ovf_result(a_q.rm, a_q.sign);
                ovf_d = 1'b1;
                inx_d = 1'b1;
            end
            default: begin
                if (exp_r >= 6'd31) begin
                    res_d = ovf_result(a_q.rm, a_q.sign);
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            b_valid     <= 1'b0;
            out_result  <= 16'h0000;
            out_ovf     <= 1'b0;
            out_inexact <= 1'b0;
        end else if (b_adv) begin
            b_valid <= a_valid;
            if (a_valid) begin
                out_result  <= res_d;
                out_ovf     <= ovf_d;
                out_inexact <= inx_d;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Scoreboard bench for fp_norm_round: directed and random bundles checked
// against an arithmetic reference model, plus backpressure and reset cases.
module tb_fp_norm_round;
    import fp16_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_rm;
    logic        in_is_nan;
    logic        in_is_inf;
    logic [9:0]  in_inf_nan_frac;
    logic        in_sign;
    logic [4:0]  in_exp;
    logic [14:0] in_frac;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_ovf;
    logic        out_inexact;

    int n_cmp = 0;
    int n_err = 0;
    int n_acc = 0;
    logic [17:0] exp_q[$];
    logic stall      = 1'b0;
    logic rand_ready = 1'b0;

    fp_norm_round dut (
        .clk             (clk),
        .clrn            (clrn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_rm           (in_rm),
        .in_is_nan       (in_is_nan),
        .in_is_inf       (in_is_inf),
        .in_inf_nan_frac (in_inf_nan_frac),
        .in_sign         (in_sign),
        .in_exp          (in_exp),
        .in_frac         (in_frac),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_ovf         (out_ovf),
        .out_inexact     (out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: returns {ovf, inexact, result} from the arithmetic rules.
    function automatic logic [17:0] ref_model(input logic [1:0] rm, input logic nan,
                                              input logic inf, input logic [9:0] nfr,
                                              input logic sg, input logic [4:0] ex,
                                              input logic [14:0] fr);
        int e, f, m, rem;
        logic up, to_inf;
        logic [15:0] res;
        if (nan) return {2'b00, sg, 5'h1F, nfr};
        if (inf) return {2'b00, sg, 15'h7C00};
        if (fr == 15'd0) return {2'b00, sg, 15'h0000};
        e = int'(ex);
        f = int'(fr);
        if ((f & 'h4000) != 0) begin
            f = (f >> 1) | (f & 1);
            e = e + 1;
        end else if (e != 0) begin
            while (((f & 'h2000) == 0) && (e > 1)) begin
                f = f << 1;
                e = e - 1;
            end
            if ((f & 'h2000) == 0) e = 0;
        end
        if (e < 31) begin
            rem = f & 7;
            m   = f >> 3;
            case (rm)
                2'b00:   up = (rem > 4) || ((rem == 4) && ((m & 1) != 0));
                2'b01:   up = sg && (rem != 0);
                2'b10:   up = !sg && (rem != 0);
                default: up = 1'b0;
            endcase
            if (up) m = m + 1;
            if (m >= 2048) begin
                m = m >> 1;
                e = e + 1;
            end else if ((e == 0) && (m >= 1024)) begin
                e = 1;
            end
            if (e < 31) begin
                res = {sg, e[4:0], m[9:0]};
                return {1'b0, (rem != 0), res};
            end
        end
        to_inf = (rm == 2'b00) || ((rm == 2'b01) && sg) || ((rm == 2'b10) && !sg);
        res = {sg, (to_inf ? 15'h7C00 : 15'h7BFF)};
        return {2'b11, res};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic send(input logic [1:0] rm, input logic nan, input logic inf,
                        input logic [9:0] nfr, input logic sg, input logic [4:0] ex,
                        input logic [14:0] fr);
        logic acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        @(negedge clk);
        in_rm = rm; in_is_nan = nan; in_is_inf = inf; in_inf_nan_frac = nfr;
        in_sign = sg; in_exp = ex; in_frac = fr; in_valid = 1'b1;
        while (!acc && (guard < 300)) begin
            #1 acc = in_ready;
            @(posedge clk);
            if (!acc) begin
                guard++;
                @(negedge clk);
            end
        end
        if (acc) begin
            exp_q.push_back(ref_model(rm, nan, inf, nfr, sg, ex, fr));
            n_acc++;
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout in_ready stuck low for %0d cycles", guard);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < budget)) begin
            @(negedge clk);
            cyc++;
        end
        repeat (2) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
    end

    // Monitor: pops one expected entry for every output transfer.
    initial begin
        logic [17:0] w;
        forever begin
            @(negedge clk);
            #2;
            if ((clrn === 1'b1) && (out_valid === 1'b1) && (out_ready === 1'b1)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output got=%h ovf=%b inx=%b want=none",
                             out_result, out_ovf, out_inexact);
                end else begin
                    w = exp_q.pop_front();
                    if ({out_ovf, out_inexact, out_result} !== w) begin
                        n_err++;
                        $display("FAIL result got=%h ovf=%b inx=%b want=%h ovf=%b inx=%b",
                                 out_result, out_ovf, out_inexact, w[15:0], w[17], w[16]);
                    end
                end
            end
        end
    end

    initial begin
        int seen;
        clrn = 1'b0;
        in_valid = 1'b0; in_rm = 2'b00; in_is_nan = 1'b0; in_is_inf = 1'b0;
        in_inf_nan_frac = 10'h0; in_sign = 1'b0; in_exp = 5'h0; in_frac = 15'h0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 16'h0000);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_inexact", out_inexact, 0);
        @(negedge clk);
        clrn = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        // Directed vectors
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd15, 15'h4000);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd15, 15'h0008);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd3,  15'h0008);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd15, 15'h200C);
        send(RM_RTZ, 0, 0, 10'h0, 0, 5'd15, 15'h200C);
        send(RM_RDN, 0, 0, 10'h0, 1, 5'd15, 15'h200C);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd30, 15'h4000);
        send(RM_RTZ, 0, 0, 10'h0, 0, 5'd30, 15'h4000);
        send(RM_RUP, 0, 0, 10'h0, 1, 5'd30, 15'h4000);
        send(RM_RNE, 1, 0, 10'h200, 0, 5'd0, 15'h1234);
        send(RM_RNE, 1, 1, 10'h155, 1, 5'd7, 15'h0);
        send(RM_RNE, 0, 1, 10'h3FF, 1, 5'd9, 15'h2000);
        send(RM_RNE, 0, 0, 10'h0, 1, 5'd12, 15'h0000);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd0, 15'h1FFF);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd30, 15'h3FFC);
        idle();
        wait_drain(50);

        // Backpressure: capacity two, then release and drain in order
        stall = 1'b1;
        repeat (2) @(negedge clk);
        n_acc = 0;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    send(2'($urandom_range(0, 3)), 0, 0, 10'h0, 1'($urandom_range(0, 1)),
                         5'($urandom_range(1, 30)), 15'($urandom_range(0, 32767)));
                idle();
            end
        join_none
        repeat (6) @(negedge clk);
        #1;
        check("bp_accepted", n_acc, 2);
        check("bp_in_ready", in_ready, 0);
        stall = 1'b0;
        wait_drain(50);
        check("bp_all_accepted", n_acc, 4);

        // Random traffic with random output stalls
        rand_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            send(2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 15) == 0), 10'($urandom_range(0, 1023)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 3) == 0) ? 15'($urandom_range(0, 31))
                                              : 15'($urandom_range(0, 32767)));
            if ($urandom_range(0, 7) == 0) idle();
        end
        idle();
        wait_drain(2000);
        rand_ready = 1'b0;

        // Reset mid-stream: in-flight results are dropped
        stall = 1'b1;
        repeat (2) @(negedge clk);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd15, 15'h4000);
        send(RM_RNE, 0, 0, 10'h0, 1, 5'd20, 15'h2008);
        @(negedge clk);
        in_valid = 1'b0;
        clrn = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_result", out_result, 16'h0000);
        check("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        clrn  = 1'b1;
        stall = 1'b0;
        seen  = 0;
        repeat (8) begin
            @(negedge clk);
            #1 if (out_valid) seen++;
        end
        check("no_stale_output", seen, 0);
        send(RM_RNE, 0, 0, 10'h0, 0, 5'd15, 15'h4000);
        idle();
        wait_drain(50);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule
